spi_config_master: RTL and testbench
====================================

SPI_CONFIG_MASTER -- requirements
Module: spi_config_master

Interface
REQ-001 Parameter halfper, default 4: SCLK half-period in clk cycles; legal range 1..255.
REQ-002 Parameter gap, default 8: minimum CSB-high clk cycles between frames; legal range 1..255.
REQ-003 Port clk  input  1: single clock for all logic.
REQ-004 Port rst  input  1: reset, asynchronous, active-high.
REQ-005 Port req_valid  input  1: request to send one 16-bit config word.
REQ-006 Port req_ready  output  1: block idle and able to accept a request.
REQ-007 Port req_addr  input  8: word bits 15:8 (command nibble plus address nibble).
REQ-008 Port req_data  input  8: word bits 7:0.
REQ-009 Port resp_valid  output  1: one-cycle strobe; the frame is complete.
REQ-010 Port resp_data  output  8: last 8 MISO bits captured in the frame.
REQ-011 Port busy  output  1: a frame or inter-frame gap is in progress.
REQ-012 Port SCLK  output  1: SPI clock, mode 0, idles low.
REQ-013 Port CSB  output  1: chip select, active-low, idles high.
REQ-014 Port MOSI  output  1: serial data to the spi_gate-style slave.
REQ-015 Port MISO  input  1: serial data from the slave, already synchronous to clk.

Function
REQ-016 States SHALL be IDLE, SHIFT_LO, SHIFT_HI, GAP. No other states are permitted.
REQ-017 req_ready SHALL be 1 exactly when the state is IDLE.
REQ-018 busy SHALL equal ~req_ready.
REQ-019 A request SHALL be accepted when req_valid and req_ready are both 1.
REQ-020 On acceptance, {req_addr, req_data} SHALL be latched into a 16-bit shift register, and the state SHALL go to SHIFT_LO.
REQ-021 req_valid SHALL be ignored outside IDLE, and input changes after acceptance SHALL NOT affect the frame in flight.
REQ-022 SCLK, CSB, MOSI, resp_valid and resp_data SHALL be driven directly from flops, with no combinational path to the outputs.
REQ-023 CSB SHALL fall on the first cycle after acceptance, with MOSI = word bit 15 on that same cycle.
REQ-024 Bits SHALL be sent MSB first; word bit 15 goes out first.
REQ-025 Each SHIFT_LO and each SHIFT_HI phase SHALL last exactly halfper cycles, counted by a phase counter.
REQ-026 SCLK SHALL be 0 in SHIFT_LO and 1 in SHIFT_HI.
REQ-027 MOSI SHALL change only on the cycle SHIFT_HI ends (the SCLK falling edge), to the next bit.
REQ-028 MISO SHALL be sampled into a 16-bit input shift register on the cycle SHIFT_LO ends (the cycle SCLK rises).
REQ-029 A 5-bit bit counter SHALL count completed SHIFT_HI phases.
REQ-030 After the 16th SHIFT_HI, one extra SHIFT_LO hold phase (halfper cycles) SHALL run with CSB still low, and MOSI SHALL be 0 during it.
REQ-031 At the end of the hold phase: CSB goes to 1, resp_valid pulses for 1 cycle, resp_data = input shift register bits 7:0, and the state goes to GAP.
REQ-032 CSB low time SHALL be exactly 33*halfper cycles; this is 132 cycles at the default halfper.
REQ-033 GAP SHALL last gap cycles with CSB=1 and SCLK=0, then return to IDLE.
REQ-034 The earliest acceptance of the next request SHALL be gap cycles after the resp_valid cycle.
REQ-035 resp_data SHALL hold its value until the next resp_valid.
REQ-036 With halfper=1, SCLK SHALL be a clean clk/2 square wave, and REQ-016..035 SHALL still hold.
REQ-037 The counters SHALL NOT wrap within a frame; the bit counter is reset on acceptance.

Reset
REQ-038 While rst=1, outputs SHALL be: state IDLE, CSB=1, SCLK=0, MOSI=0, resp_valid=0, resp_data=0, busy=0, and req_ready=1 once rst deasserts.
REQ-039 Reset asserted mid-frame SHALL abort immediately and asynchronously, with no resp_valid for the aborted word.
REQ-040 After rst deasserts, the next request SHALL be accepted on the first cycle it is presented.

Verification
REQ-041 Scenario 1: halfper=4, gap=8, send addr 0x12, data 0x34, with a spi_gate model on the bus.
- Required response: exactly 16 SCLK rising edges; CSB low for 132 cycles.
- Required response: the model sees config_a=0x12, config_d=0x34 and a single config_w.
- Required response: resp_valid is one cycle.
REQ-042 Scenario 2: MISO driven with pattern 0x00A5 over the frame.
- Required response: resp_data=0xA5 at resp_valid.
REQ-043 Scenario 3: req_valid held high continuously with addr 0x20, data 0x01, then 0x21/0x00.
- Required response: two frames, separated by exactly 8 CSB-high cycles after the first resp_valid.
- Required response: req_ready is low throughout frame 1.
REQ-044 Scenario 4: rst pulsed on the 40th cycle of a frame.
- Required response: CSB=1 and SCLK=0 in the same cycle.
- Required response: no resp_valid for the aborted word; the next word 0x30/0x55 is sent intact.
REQ-045 Scenario 5: halfper=1, word 0xFFFF, then 0x0000.
- Required response: SCLK period is 2 cycles; CSB low time is 33 cycles.
- Required response: MOSI is stable at every rising edge; the model decodes both words.
REQ-046 Scenario 6: req_addr and req_data toggled every cycle after acceptance of 0x1A/0xC3.
- Required response: the slave receives 0x1AC3.

Source files
------------

// File: rtl/spi_config_master_if.sv
// Request/response bundle of the SPI configuration master.
//   req_valid/req_ready : handshake for one 16-bit config word
//   req_addr/req_data   : word bits 15:8 and 7:0
//   resp_valid          : one-cycle strobe when a frame completes
//   resp_data           : last 8 MISO bits captured in the frame
//   busy                : frame or inter-frame gap in progress
// The master modport is the requesting side; the slave modport is the
// SPI engine that serves the request.
interface spi_config_master_if;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_addr;
    logic [7:0] req_data;
    logic       resp_valid;
    logic [7:0] resp_data;
    logic       busy;

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, resp_valid, resp_data, busy
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, resp_valid, resp_data, busy
    );
endinterface

// File: rtl/spi_config_master.sv
// SPI mode-0 master that sends one 16-bit configuration word per request,
// MSB first, and returns the last 8 bits read back on MISO.
//   clk, rst  : single clock, asynchronous active-high reset
//   req_if    : request/response bundle (slave side)
//   SCLK      : SPI clock, idles low, half-period = halfper clk cycles
//   CSB       : active-low chip select, low for exactly 33*halfper cycles
//   MOSI      : serial data out, changes on SCLK falling edge
//   MISO      : serial data in, already synchronous to clk
// A frame is 16 SHIFT_LO/SHIFT_HI pairs followed by one extra SHIFT_LO hold
// phase with MOSI low, then a GAP of `gap` cycles with CSB high.
module spi_config_master #(
    parameter int unsigned halfper = 4,
    parameter int unsigned gap     = 8
) (
    input  logic               clk,
    input  logic               rst,
    spi_config_master_if.slave req_if,
    output logic               SCLK,
    output logic               CSB,
    output logic               MOSI,
    input  logic               MISO
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2,
        GAP      = 2'd3
    } state_t;

    localparam logic [7:0] PHASE_LAST = 8'(halfper - 1);
    localparam logic [7:0] GAP_LAST   = 8'(gap - 1);
    localparam logic [4:0] LAST_BIT   = 5'd15;
    // Bit counter value that marks the trailing hold phase.
    localparam logic [4:0] HOLD_MARK  = 5'd16;

    state_t      state_r, state_s;
    logic [7:0]  phase_r, phase_s;
    logic [4:0]  bit_r, bit_s;
    logic [15:0] tx_r, tx_s;
    logic [15:0] rx_r, rx_s;
    logic        csb_r, csb_s;
    logic        sclk_r, sclk_s;
    logic        mosi_r, mosi_s;
    logic        rvalid_r, rvalid_s;
    logic [7:0]  rdata_r, rdata_s;
    logic        phase_end_s;
    logic        gap_end_s;

    // Next-state and next-output computation for the frame sequencer.
    always_comb begin
        state_s     = state_r;
        phase_s     = phase_r;
        bit_s       = bit_r;
        tx_s        = tx_r;
        rx_s        = rx_r;
        csb_s       = csb_r;
        sclk_s      = sclk_r;
        mosi_s      = mosi_r;
        rvalid_s    = 1'b0;
        rdata_s     = rdata_r;
        phase_end_s = (phase_r == PHASE_LAST);
        gap_end_s   = (phase_r == GAP_LAST);

        case (state_r)
            IDLE: begin
                phase_s = 8'd0;
                if (req_if.req_valid) begin
                    // CSB and the first bit go out on the very next cycle.
                    state_s = SHIFT_LO;
                    tx_s    = {req_if.req_addr, req_if.req_data};
                    bit_s   = 5'd0;
                    csb_s   = 1'b0;
                    sclk_s  = 1'b0;
                    mosi_s  = req_if.req_addr[7];
                end else begin
                    csb_s  = 1'b1;
                    sclk_s = 1'b0;
                    mosi_s = 1'b0;
                end
            end

            SHIFT_LO: begin
                if (!phase_end_s) begin
                    phase_s = phase_r + 8'd1;
                end else if (bit_r == HOLD_MARK) begin
                    // Hold phase done: release CSB and report the read-back.
                    phase_s  = 8'd0;
                    state_s  = GAP;
                    csb_s    = 1'b1;
                    mosi_s   = 1'b0;
                    rvalid_s = 1'b1;
                    rdata_s  = rx_r[7:0];
                end else begin
                    // SCLK rises next cycle; MISO is captured at this edge.
                    phase_s = 8'd0;
                    state_s = SHIFT_HI;
                    sclk_s  = 1'b1;
                    rx_s    = {rx_r[14:0], MISO};
                end
            end

            SHIFT_HI: begin
                if (!phase_end_s) begin
                    phase_s = phase_r + 8'd1;
                end else begin
                    phase_s = 8'd0;
                    state_s = SHIFT_LO;
                    sclk_s  = 1'b0;
                    bit_s   = bit_r + 5'd1;
                    tx_s    = {tx_r[14:0], 1'b0};
                    if (bit_r == LAST_BIT) begin
                        mosi_s = 1'b0;
                    end else begin
                        mosi_s = tx_r[14];
                    end
                end
            end

            GAP: begin
                if (gap_end_s) begin
                    phase_s = 8'd0;
                    state_s = IDLE;
                end else begin
                    phase_s = phase_r + 8'd1;
                end
            end

            default: begin
                state_s = IDLE;
                phase_s = 8'd0;
                csb_s   = 1'b1;
                sclk_s  = 1'b0;
                mosi_s  = 1'b0;
            end
        endcase
    end

    // State register plus all datapath and output flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            phase_r  <= 8'd0;
            bit_r    <= 5'd0;
            tx_r     <= 16'd0;
            rx_r     <= 16'd0;
            csb_r    <= 1'b1;
            sclk_r   <= 1'b0;
            mosi_r   <= 1'b0;
            rvalid_r <= 1'b0;
            rdata_r  <= 8'd0;
        end else begin
            state_r  <= state_s;
            phase_r  <= phase_s;
            bit_r    <= bit_s;
            tx_r     <= tx_s;
            rx_r     <= rx_s;
            csb_r    <= csb_s;
            sclk_r   <= sclk_s;
            mosi_r   <= mosi_s;
            rvalid_r <= rvalid_s;
            rdata_r  <= rdata_s;
        end
    end

    assign req_if.req_ready  = (state_r == IDLE);
    assign req_if.busy       = (state_r != IDLE);
    assign req_if.resp_valid = rvalid_r;
    assign req_if.resp_data  = rdata_r;
    assign SCLK              = sclk_r;
    assign CSB               = csb_r;
    assign MOSI              = mosi_r;

endmodule

// File: tb/tb_spi_config_master.sv
// Self-checking bench for spi_config_master: one instance with halfper=4 and
// one with halfper=1 share a spi_gate-style slave model through a selector.
module tb_spi_config_master;

    logic clk = 1'b0;
    logic rst;
    logic miso;
    logic sel;                 // 0: halfper=4 instance, 1: halfper=1 instance
    logic sclk0, csb0, mosi0, sclk1, csb1, mosi1;

    int n_checks = 0;
    int n_errors = 0;

    spi_config_master_if if0 ();
    spi_config_master_if if1 ();

    spi_config_master #(.halfper(4), .gap(8)) u_dut4 (
        .clk(clk), .rst(rst), .req_if(if0),
        .SCLK(sclk0), .CSB(csb0), .MOSI(mosi0), .MISO(miso)
    );

    spi_config_master #(.halfper(1), .gap(8)) u_dut1 (
        .clk(clk), .rst(rst), .req_if(if1),
        .SCLK(sclk1), .CSB(csb1), .MOSI(mosi1), .MISO(miso)
    );

    always #5 clk = ~clk;

    logic       m_sclk, m_csb, m_mosi, m_rv, m_ready, m_busy, m_valid;
    logic [7:0] m_rd;
    assign m_sclk  = sel ? sclk1 : sclk0;
    assign m_csb   = sel ? csb1 : csb0;
    assign m_mosi  = sel ? mosi1 : mosi0;
    assign m_rv    = sel ? if1.resp_valid : if0.resp_valid;
    assign m_rd    = sel ? if1.resp_data : if0.resp_data;
    assign m_ready = sel ? if1.req_ready : if0.req_ready;
    assign m_busy  = sel ? if1.busy : if0.busy;
    assign m_valid = sel ? if1.req_valid : if0.req_valid;

    // Scoreboard queues
    logic [15:0] word_q[$];    // words expected at the slave
    logic [15:0] miso_q[$];    // MISO pattern per accepted frame
    logic [7:0]  resp_q[$];    // expected resp_data per completed frame

    logic aborting = 1'b0;
    int   cfg_w_cnt = 0;
    int   rv_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // spi_gate slave model, MISO driver and frame/timing monitor
    initial begin : monitor
        int          cyc, rise_cnt, low_cnt, last_rise, since_rv, hp;
        logic        prev_csb, prev_sclk, prev_mosi, prev_rv, in_gap;
        logic [15:0] rx_word, cur_miso, exp_w;
        logic [7:0]  config_a, config_d, last_rd0, last_rd1, exp_rd;
        cyc = 0; rise_cnt = 0; low_cnt = 0; last_rise = -1; since_rv = 0;
        prev_csb = 1'b1; prev_sclk = 1'b0; prev_mosi = 1'b0; prev_rv = 1'b0;
        in_gap = 1'b0; rx_word = 16'd0; cur_miso = 16'd0;
        last_rd0 = 8'd0; last_rd1 = 8'd0;
        miso = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            hp = sel ? 1 : 4;
            check("busy_eq_not_ready", m_busy, !m_ready);
            if (rst) begin
                check("rst_csb", m_csb, 1'b1);
                check("rst_sclk", m_sclk, 1'b0);
                check("rst_mosi", m_mosi, 1'b0);
                check("rst_resp_valid", m_rv, 1'b0);
                check("rst_resp_data", m_rd, 8'h00);
                last_rd0 = 8'd0;
                last_rd1 = 8'd0;
                in_gap   = 1'b0;
            end
            if (prev_csb && !m_csb) begin
                if (in_gap) check("gap_csb_high_cycles", since_rv, 8);
                in_gap = 1'b0;
                rise_cnt = 0; low_cnt = 0; last_rise = -1; rx_word = 16'd0;
                check("miso_pattern_avail", miso_q.size() != 0, 1'b1);
                cur_miso = (miso_q.size() != 0) ? miso_q.pop_front() : 16'd0;
            end
            if (!m_csb) begin
                low_cnt++;
                check("ready_low_in_frame", m_ready, 1'b0);
                if (rise_cnt == 16 && !m_sclk) check("hold_mosi_zero", m_mosi, 1'b0);
                if (!prev_sclk && m_sclk) begin
                    check("mosi_stable_at_rise", m_mosi, prev_mosi);
                    if (last_rise >= 0) check("sclk_period", cyc - last_rise, 2 * hp);
                    last_rise = cyc;
                    rise_cnt++;
                    rx_word = {rx_word[14:0], m_mosi};
                end
            end else begin
                check("sclk_low_when_csb_high", m_sclk, 1'b0);
            end
            if (!prev_csb && m_csb) begin
                if (aborting) begin
                    check("abort_partial_frame", rise_cnt < 16, 1'b1);
                    if (word_q.size() != 0) void'(word_q.pop_front());
                    aborting = 1'b0;
                end else begin
                    check("sclk_rises", rise_cnt, 16);
                    check("csb_low_cycles", low_cnt, 33 * hp);
                    check("word_avail", word_q.size() != 0, 1'b1);
                    exp_w = (word_q.size() != 0) ? word_q.pop_front() : 16'd0;
                    config_a = rx_word[15:8];
                    config_d = rx_word[7:0];
                    cfg_w_cnt++;
                    check("config_a", config_a, exp_w[15:8]);
                    check("config_d", config_d, exp_w[7:0]);
                    resp_q.push_back(cur_miso[7:0]);
                end
            end
            if (m_rv) begin
                rv_cnt++;
                check("resp_valid_one_cycle", prev_rv, 1'b0);
                check("resp_csb_high", m_csb, 1'b1);
                check("resp_avail", resp_q.size() != 0, 1'b1);
                exp_rd = (resp_q.size() != 0) ? resp_q.pop_front() : 8'd0;
                check("resp_data", m_rd, exp_rd);
                if (sel) last_rd1 = exp_rd; else last_rd0 = exp_rd;
                since_rv = 0;
                in_gap = 1'b1;
            end else if (!rst) begin
                check("resp_data_hold", m_rd, sel ? last_rd1 : last_rd0);
                if (in_gap && m_csb) since_rv++;
                if (m_ready && !m_valid) in_gap = 1'b0;
            end
            miso = (!m_csb && rise_cnt < 16) ? cur_miso[15 - rise_cnt] : 1'b0;
            prev_csb = m_csb; prev_sclk = m_sclk; prev_mosi = m_mosi; prev_rv = m_rv;
        end
    end

    task automatic set_bus(input logic v, input logic [7:0] a, input logic [7:0] d);
        if0.req_valid = v & ~sel;
        if1.req_valid = v & sel;
        if0.req_addr = a; if1.req_addr = a;
        if0.req_data = d; if1.req_data = d;
    endtask

    // Present a request (call at a negedge); returns #1 after the accepting edge.
    task automatic do_send(input logic [7:0] a, input logic [7:0] d, input logic [15:0] pat,
                           input bit hold, output int waited);
        waited = 0;
        set_bus(1'b1, a, d);
        while (!m_ready && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        check("accept_ready", m_ready, 1'b1);
        @(posedge clk);
        word_q.push_back({a, d});
        miso_q.push_back(pat);
        #1;
        if (!hold) set_bus(1'b0, a, d);
    endtask

    task automatic wait_resp(input bit toggle);
        int n;
        n = 0;
        @(negedge clk);
        while (!m_rv && n < 2000) begin
            @(negedge clk);
            n++;
            if (toggle) set_bus(1'b0, 8'($urandom), 8'($urandom));
        end
        check("resp_seen", m_rv, 1'b1);
        repeat (12) @(negedge clk);
    endtask

    // Directed stimulus
    initial begin : stimulus
        int w;
        sel = 1'b0;
        rst = 1'b1;
        set_bus(1'b0, 8'h00, 8'h00);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_ready", m_ready, 1'b1);
        check("post_reset_busy", m_busy, 1'b0);

        // Basic word with an arbitrary read-back pattern
        do_send(8'h12, 8'h34, 16'h5A3C, 1'b0, w);
        wait_resp(1'b0);
        // MISO pattern 0x00A5
        do_send(8'h40, 8'h77, 16'h00A5, 1'b0, w);
        wait_resp(1'b0);
        // req_valid held high across two frames
        do_send(8'h20, 8'h01, 16'h1234, 1'b1, w);
        @(negedge clk);
        do_send(8'h21, 8'h00, 16'hFF0F, 1'b0, w);
        wait_resp(1'b0);
        // Reset on the 40th cycle of a frame
        do_send(8'h77, 8'h88, 16'hAAAA, 1'b0, w);
        repeat (39) @(posedge clk);
        #2;
        aborting = 1'b1;
        rst = 1'b1;
        #1;
        check("abort_csb_async", m_csb, 1'b1);
        check("abort_sclk_async", m_sclk, 1'b0);
        check("abort_no_resp", m_rv, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        do_send(8'h30, 8'h55, 16'h0F0F, 1'b0, w);
        check("first_cycle_accept", w, 0);
        wait_resp(1'b0);
        // halfper=1 instance
        sel = 1'b1;
        @(negedge clk);
        do_send(8'hFF, 8'hFF, 16'h8001, 1'b0, w);
        wait_resp(1'b0);
        do_send(8'h00, 8'h00, 16'h7E7E, 1'b0, w);
        wait_resp(1'b0);
        sel = 1'b0;
        @(negedge clk);
        // Inputs toggling after acceptance
        do_send(8'h1A, 8'hC3, 16'hC35A, 1'b0, w);
        wait_resp(1'b1);

        check("config_w_count", cfg_w_cnt, 8);
        check("resp_valid_count", rv_cnt, 8);
        check("word_q_drained", word_q.size(), 0);
        check("resp_q_drained", resp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
